// File: rtl/nios_recv_data_pio_edge.sv
// Avalon-MM input PIO for the Nios receive path with per-bit edge capture.
//
// An external bus is brought into the clk domain through a SYNC_STAGES-deep
// flop chain. Edges of the configured type (EDGE_TYPE) are detected on the
// synchronised value. Detected edges are held in sticky, write-1-to-clear
// capture bits, and a snapshot of the whole bus is taken on any edge.
// A level irq is raised while any captured bit is enabled in the mask.
//
// Ports:
//   clk, reset_n  - system clock; asynchronous active-low reset
//   address       - word address: 0 DATA, 1 IRQ_MASK, 2 SNAPSHOT, 3 EDGE_CAPTURE
//   chipselect    - qualifies writes together with write_n
//   write_n       - active-low write strobe
//   writedata     - write data (only the low DATA_WIDTH bits are used)
//   readdata      - registered read data, one cycle after the address
//   in_port       - asynchronous external input bus
//   irq           - registered level interrupt
module nios_recv_data_pio_edge #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    SYNC_STAGES    = 2,
    parameter int                    EDGE_TYPE      = 0,
    parameter logic [DATA_WIDTH-1:0] IRQ_RESET_MASK = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync;
    logic [DATA_WIDTH-1:0] data_sync;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] ev;
    logic [DATA_WIDTH-1:0] edge_capture;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] snapshot;
    logic [DATA_WIDTH-1:0] clr;
    logic                  wr_en;
    logic [31:0]           rd_mux;

    assign data_sync = sync[SYNC_STAGES-1];
    assign wr_en     = chipselect & ~write_n;

    // Synchroniser chain plus the one-cycle-old copy used for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= '0;
        end else begin
            sync[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync[k] <= sync[k-1];
            prev <= data_sync;
        end
    end

    always_comb begin
        ev = '0;
        case (EDGE_TYPE)
            0:       ev = data_sync & ~prev;
            1:       ev = ~data_sync & prev;
            default: ev = data_sync ^ prev;
        endcase
    end

    assign clr = (wr_en && address == 2'd3) ? writedata[DATA_WIDTH-1:0] : '0;

    // OR-ing ev after the clear lets a same-cycle edge win over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            snapshot     <= '0;
            irq_mask     <= IRQ_RESET_MASK;
        end else begin
            edge_capture <= (edge_capture & ~clr) | ev;
            if (|ev)
                snapshot <= data_sync;
            if (wr_en && address == 2'd1)
                irq_mask <= writedata[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[DATA_WIDTH-1:0] = data_sync;
            2'd1: rd_mux[DATA_WIDTH-1:0] = irq_mask;
            2'd2: rd_mux[DATA_WIDTH-1:0] = snapshot;
            2'd3: rd_mux[DATA_WIDTH-1:0] = edge_capture;
            default: rd_mux = '0;
        endcase
    end

    // irq uses the pre-update capture/mask, so it trails them by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_nios_recv_data_pio_edge.sv
module tb_nios_recv_data_pio_edge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic [3:0]  cs = '0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] in_def = '0;
    logic [7:0]  in_fall = 8'hFF;
    logic [7:0]  in_any = 8'h0F;
    logic [7:0]  in_w8 = 8'h00;
    logic [31:0] rdata [4];
    logic        irqv  [4];

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    // 0: defaults, rising edges, 32 bits
    nios_recv_data_pio_edge u_def (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
        .write_n(write_n), .writedata(writedata), .readdata(rdata[0]),
        .in_port(in_def), .irq(irqv[0]));

    // 1: falling edges, 8 bits
    nios_recv_data_pio_edge #(.DATA_WIDTH(8), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
        .write_n(write_n), .writedata(writedata), .readdata(rdata[1]),
        .in_port(in_fall), .irq(irqv[1]));

    // 2: any edge, 8 bits
    nios_recv_data_pio_edge #(.DATA_WIDTH(8), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
        .write_n(write_n), .writedata(writedata), .readdata(rdata[2]),
        .in_port(in_any), .irq(irqv[2]));

    // 3: 8 bits, non-zero reset mask
    nios_recv_data_pio_edge #(.DATA_WIDTH(8), .IRQ_RESET_MASK(8'h81)) u_w8 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[3]),
        .write_n(write_n), .writedata(writedata), .readdata(rdata[3]),
        .in_port(in_w8), .irq(irqv[3]));

    typedef struct {
        logic [31:0] in_p;
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(input int inst, input logic [1:0] a, input logic [31:0] d);
        address   = a;
        cs        = '0;
        cs[inst]  = 1'b1;
        write_n   = 1'b0;
        writedata = d;
        @(negedge clk);
        cs      = '0;
        write_n = 1'b1;
    endtask

    task automatic rd(input int inst, input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        cs      = '0;
        write_n = 1'b1;
        @(negedge clk);
        check(name, rdata[inst], exp);
    endtask

    initial begin
        // Each row drives for one clock; readdata/irq are compared at the
        // following negedge, i.e. they reflect state before that posedge.
        //          in_p         addr  cs    wn    wd            exp_rd        irq
        tbl[0]  = '{32'h0, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0}; // reset reads
        tbl[1]  = '{32'h0, 2'd1, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        tbl[2]  = '{32'h0, 2'd2, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        tbl[3]  = '{32'h0, 2'd3, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        tbl[4]  = '{32'h8, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0}; // edge 1
        tbl[5]  = '{32'h8, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0}; // edge 2
        tbl[6]  = '{32'h8, 2'd0, 1'b0, 1'b1, 32'h0,        32'h8, 1'b0}; // edge 3: captured
        tbl[7]  = '{32'h8, 2'd3, 1'b0, 1'b1, 32'h0,        32'h8, 1'b0};
        tbl[8]  = '{32'h8, 2'd2, 1'b0, 1'b1, 32'h0,        32'h8, 1'b0};
        tbl[9]  = '{32'h8, 2'd1, 1'b1, 1'b0, 32'h8,        32'h0, 1'b0}; // mask write
        tbl[10] = '{32'h8, 2'd1, 1'b0, 1'b1, 32'h0,        32'h8, 1'b1}; // irq next cycle
        tbl[11] = '{32'h8, 2'd3, 1'b1, 1'b0, 32'h8,        32'h8, 1'b1}; // W1C
        tbl[12] = '{32'h8, 2'd3, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        tbl[13] = '{32'h0, 2'd0, 1'b0, 1'b1, 32'h0,        32'h8, 1'b0}; // drop bit 3
        tbl[14] = '{32'h0, 2'd0, 1'b0, 1'b1, 32'h0,        32'h8, 1'b0};
        tbl[15] = '{32'h0, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        tbl[16] = '{32'h8, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0}; // rise again
        tbl[17] = '{32'h8, 2'd3, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        tbl[18] = '{32'h8, 2'd3, 1'b1, 1'b0, 32'h8,        32'h0, 1'b0}; // edge meets W1C
        tbl[19] = '{32'h8, 2'd3, 1'b0, 1'b1, 32'h0,        32'h8, 1'b1}; // edge won
        tbl[20] = '{32'h8, 2'd3, 1'b1, 1'b0, 32'h8,        32'h8, 1'b1};
        tbl[21] = '{32'h8, 2'd3, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        tbl[22] = '{32'h8, 2'd2, 1'b0, 1'b1, 32'h0,        32'h8, 1'b0};
        tbl[23] = '{32'h8, 2'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8, 1'b0}; // DATA is RO
        tbl[24] = '{32'h8, 2'd0, 1'b0, 1'b1, 32'h0,        32'h8, 1'b0};
        tbl[25] = '{32'h8, 2'd1, 1'b0, 1'b0, 32'h0,        32'h8, 1'b0}; // no chipselect
        tbl[26] = '{32'h8, 2'd1, 1'b0, 1'b1, 32'h0,        32'h8, 1'b0};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            in_def    = tbl[i].in_p;
            address   = tbl[i].addr;
            cs        = {3'b000, tbl[i].cs};
            write_n   = tbl[i].wn;
            writedata = tbl[i].wd;
            @(negedge clk);
            check($sformatf("vec%0d rd", i), rdata[0], tbl[i].exp_rd);
            check($sformatf("vec%0d irq", i), {31'b0, irqv[0]}, {31'b0, tbl[i].exp_irq});
        end
        cs = '0;
        write_n = 1'b1;

        // Falling edges: FF held since reset gives no falling edge; FF->0F does.
        rd(1, 2'd3, 32'h0, "fall ec idle");
        in_fall = 8'h0F;
        repeat (4) cyc();
        rd(1, 2'd3, 32'hF0, "fall ec");
        rd(1, 2'd2, 32'h0F, "fall snapshot");

        // Any edge: 0F after reset captured as 0F; clear then 0F->3C.
        rd(2, 2'd3, 32'h0F, "any ec from reset");
        wr(2, 2'd3, 32'hFF);
        rd(2, 2'd3, 32'h0, "any ec cleared");
        in_any = 8'h3C;
        repeat (4) cyc();
        rd(2, 2'd3, 32'h33, "any ec");
        rd(2, 2'd2, 32'h3C, "any snapshot");

        // 8-bit instance: mask width, RO data, reset mid-stream.
        rd(3, 2'd1, 32'h81, "w8 reset mask");
        wr(3, 2'd1, 32'hFFFF_FFFF);
        rd(3, 2'd1, 32'hFF, "w8 mask trunc");
        wr(3, 2'd0, 32'hFFFF_FFFF);
        rd(3, 2'd0, 32'h0, "w8 data ro");
        in_w8 = 8'h01;
        repeat (4) cyc();
        rd(3, 2'd3, 32'h01, "w8 ec");
        check("w8 irq high", {31'b0, irqv[3]}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("w8 irq async reset", {31'b0, irqv[3]}, 32'h0);
        check("w8 rd async reset", rdata[3], 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3, 2'd1, 32'h81, "w8 mask after reset");
        check("w8 irq e1", {31'b0, irqv[3]}, 32'h0);
        cyc();
        rd(3, 2'd3, 32'h0, "w8 ec e3");
        rd(3, 2'd3, 32'h01, "w8 ec re-edge");
        check("w8 irq re-edge", {31'b0, irqv[3]}, 32'h1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
